i2c_reg_reader: RTL and testbench

I2C_REG_READER -- requirements
Module: i2c_reg_reader

---
 rtl/i2c_reg_reader.sv | 131 +++++++++++++
 tb/tb_i2c_reg_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_reader.sv
// i2c_reg_reader: I2C master that reads one register (write reg index, repeated start, read one byte).
// Each bit slot has four quarters of CLK_DIV cycles; line outputs are registered from next-state decode.
module i2c_reg_reader #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {IDLE, START, WR_BIT, WR_ACK, RSTART, RD_BIT, RD_NACK, STOP, DONE} state_t;

    state_t state, nstate;
    logic [DW-1:0] div, ndiv;
    logic [1:0] q, nq, byte_idx, nbyte;
    logic [2:0] bit_cnt, nbit;
    logic [6:0] dev_q;
    logic [7:0] reg_q, rd_sh, wr_byte;
    logic tick, slot_end, sample, nscl, nsda;

    assign tick = div == DW'(CLK_DIV - 1);
    assign slot_end = tick && q == 2'd3;
    assign sample = div == '0 && q == 2'd3;

    always_comb begin
        nstate = state;
        ndiv = tick ? '0 : div + 1'b1;
        nq = tick ? q + 2'd1 : q;
        nbit = bit_cnt;
        nbyte = byte_idx;
        case (state)
            IDLE: begin
                ndiv = '0;
                nq = '0;
                nbit = '0;
                nbyte = '0;
                nstate = start ? START : IDLE;
            end
            START, RSTART: nstate = slot_end ? WR_BIT : state;
            WR_BIT: if (slot_end) begin
                nstate = bit_cnt == 3'd7 ? WR_ACK : WR_BIT;
                nbit = bit_cnt + 3'd1;
            end
            // a NACK skips straight to STOP; otherwise byte 1 is followed by the repeated start
            WR_ACK: if (slot_end) begin
                nstate = ack_err ? STOP : byte_idx == 2'd0 ? WR_BIT : byte_idx == 2'd1 ? RSTART : RD_BIT;
                nbyte = byte_idx == 2'd2 ? byte_idx : byte_idx + 2'd1;
            end
            RD_BIT: if (slot_end) begin
                nstate = bit_cnt == 3'd7 ? RD_NACK : RD_BIT;
                nbit = bit_cnt + 3'd1;
            end
            RD_NACK: nstate = slot_end ? STOP : RD_NACK;
            STOP: nstate = slot_end ? DONE : STOP;
            default: nstate = IDLE;
        endcase
    end

    assign wr_byte = nbyte == 2'd0 ? {dev_q, 1'b0} : nbyte == 2'd1 ? reg_q : {dev_q, 1'b1};

    always_comb begin
        nscl = 1'b0;
        nsda = 1'b0;
        case (nstate)
            START, RSTART: nsda = nq[1];
            WR_BIT: begin
                nscl = ~nq[1];
                nsda = ~wr_byte[~nbit];
            end
            WR_ACK, RD_BIT, RD_NACK: nscl = ~nq[1];
            STOP: begin
                nscl = nq == 2'd0;
                nsda = nq != 2'd3;
            end
            default: begin
                nscl = 1'b0;
                nsda = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            div <= '0;
            q <= '0;
            bit_cnt <= '0;
            byte_idx <= '0;
            dev_q <= '0;
            reg_q <= '0;
            rd_sh <= '0;
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            ack_err <= 1'b0;
            data_out <= '0;
        end else begin
            state <= nstate;
            div <= ndiv;
            q <= nq;
            bit_cnt <= nbit;
            byte_idx <= nbyte;
            scl_oe <= nscl;
            sda_oe <= nsda;
            busy <= nstate != IDLE;
            done <= state == DONE;
            if (state == IDLE && start) begin
                dev_q <= dev_addr;
                reg_q <= reg_addr;
                ack_err <= 1'b0;
            end
            if (sample && state == WR_ACK && sda_in)
                ack_err <= 1'b1;
            if (sample && state == RD_BIT)
                rd_sh <= {rd_sh[6:0], sda_in};
            if (state == DONE && !ack_err)
                data_out <= rd_sh;
        end
    end
endmodule

// File: tb/tb_i2c_reg_reader.sv
// tb_i2c_reg_reader: randomized bench with an I2C slave at 0x48 and a slot-table model of the bus waveform.
// The model lists the slots a transaction must produce and checks lines, busy, done and data every cycle.
module tb_i2c_reg_reader;
    localparam int D = 4;
    localparam int SLOT = 4 * D;

    logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, sda_in;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0, data_out, slave_data = '0;
    logic scl_oe, sda_oe, busy, done, ack_err;
    logic slave_pull = 1'b0;

    int n_cmp = 0, n_err = 0, n_done = 0;

    i2c_reg_reader #(.CLK_DIV(D)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe), .data_out(data_out),
        .busy(busy), .done(done), .ack_err(ack_err)
    );

    assign sda_in = ~(sda_oe | slave_pull);
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: tracks SCL falls after a START, ACKs address 0x48 and returns slave_data.
    logic s_pscl = 1'b1, s_psda = 1'b1, s_on = 1'b0;
    int s_f = 0;
    logic [7:0] obs [3];
    always @(negedge clk) begin : slave
        logic scl_w, sda_w;
        logic [2:0] idx;
        int r;
        scl_w = ~scl_oe;
        sda_w = sda_in;
        if (!reset_n) begin
            slave_pull = 1'b0;
            s_on = 1'b0;
            s_f = 0;
        end else if (s_pscl && scl_w && s_psda && !sda_w) begin
            s_on = 1'b1;
            s_f = 0;
            slave_pull = 1'b0;
            for (int i = 0; i < 3; i++) obs[i] = '0;
        end else if (s_on && s_pscl && !scl_w) begin
            idx = 3'(34 - s_f);
            slave_pull = obs[0] == 8'h90 &&
                         (s_f == 8 || s_f == 17 || s_f == 26 || (s_f >= 27 && s_f <= 34 && !slave_data[idx]));
            s_f++;
        end else if (s_on && !s_pscl && scl_w) begin
            r = s_f - 1;
            if (r >= 0 && r < 27 && r % 9 != 8) obs[r / 9] = {obs[r / 9][6:0], sda_w};
        end
        s_pscl = scl_w;
        s_psda = sda_w;
    end

    // Reference model: queue of slot codes {scl_oe Q3..Q0, sda_oe Q3..Q0}.
    logic [7:0] m_q [$];
    logic m_act = 1'b0, m_ok = 1'b0, m_err = 1'b0;
    logic [7:0] m_data = '0, m_sdata = '0;
    int m_t = 0, m_L = 0, c_fall = 0, c_rise = 0;
    logic p_scl = 1'b0, p_sda = 1'b0;

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) m_q.push_back(b[i] ? 8'h30 : 8'h3F);
    endfunction

    function automatic void build();
        m_q.delete();
        m_ok = dev_addr == 7'h48;
        m_sdata = slave_data;
        m_q.push_back(8'h0C);
        push_byte({dev_addr, 1'b0});
        m_q.push_back(8'h30);
        if (m_ok) begin
            push_byte(reg_addr);
            m_q.push_back(8'h30);
            m_q.push_back(8'h0C);
            push_byte({dev_addr, 1'b1});
            for (int i = 0; i < 10; i++) m_q.push_back(8'h30);
        end
        m_q.push_back(8'h17);
        m_L = m_q.size() * SLOT;
    endfunction

    always @(negedge clk) begin : cmp
        logic [7:0] code;
        logic [3:0] exp;
        logic fin;
        int qq;
        if (done) n_done++;
        if (!reset_n) begin
            check("reset_state", {scl_oe, sda_oe, busy, done, ack_err, data_out}, 0);
            m_act = 1'b0;
            m_data = '0;
            m_err = 1'b0;
        end else begin
            fin = m_act && m_t == m_L + 1;
            exp = 4'b0000;
            if (m_act && m_t < m_L) begin
                code = m_q[m_t / SLOT];
                qq = (m_t % SLOT) / D;
                exp = {code[4 + qq], code[qq], 2'b10};
            end else if (m_act && m_t == m_L) begin
                exp = 4'b0010;
            end else if (fin) begin
                exp = 4'b0001;
                if (m_ok) m_data = m_sdata;
                m_err = !m_ok;
            end
            check("scl_sda_busy_done", {scl_oe, sda_oe, busy, done}, exp);
            check("data_out", data_out, m_data);
            if (!m_act || fin) check("ack_err", ack_err, m_err);
            if (m_act && !p_scl && !scl_oe && sda_oe != p_sda) begin
                if (sda_oe) c_fall++;
                else c_rise++;
            end
            if (fin) begin
                check("proto_start_conditions", c_fall, m_ok ? 2 : 1);
                check("proto_stop_conditions", c_rise, 1);
            end
            if ((!m_act || fin) && start) begin
                m_act = 1'b1;
                m_t = 0;
                c_fall = 0;
                c_rise = 0;
                build();
            end else if (fin) begin
                m_act = 1'b0;
            end else if (m_act) begin
                m_t++;
            end
        end
        p_scl = scl_oe;
        p_sda = sda_oe;
    end

    task automatic wait_done(input int spur, output int lat);
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (spur > 0 && lat == spur) begin
                start = 1'b1;
                dev_addr = 7'($urandom);
                reg_addr = 8'($urandom);
            end else if (spur > 0 && lat == spur + 1) begin
                start = 1'b0;
            end
            if (done) break;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic run_txn(input logic [6:0] d, input logic [7:0] r, input logic [7:0] sd,
                           input int spur, output int lat);
        dev_addr = d;
        reg_addr = r;
        slave_data = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(spur, lat);
    endtask

    initial begin
        int lat, nd, spur;
        logic [6:0] d;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run_txn(7'h48, 8'h05, 8'hA7, 0, lat);
        check("ok_latency", lat, 625);
        check("ok_data", data_out, 8'hA7);
        check("ok_ack_err", ack_err, 0);
        check("sda_byte0", obs[0], 8'h90);
        check("sda_byte1", obs[1], 8'h05);
        check("sda_byte2", obs[2], 8'h91);

        run_txn(7'h21, 8'h33, 8'h5A, 0, lat);
        check("nack_latency", lat, 177);
        check("nack_ack_err", ack_err, 1);
        check("nack_data_kept", data_out, 8'hA7);

        run_txn(7'h48, 8'h10, 8'h00, 0, lat);
        check("data_zero", data_out, 8'h00);
        run_txn(7'h48, 8'hFF, 8'hFF, 0, lat);
        check("data_ones", data_out, 8'hFF);

        dev_addr = 7'h48;
        reg_addr = 8'h11;
        slave_data = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, lat);
        check("held_first_latency", lat, 625);
        check("held_data", data_out, 8'h3C);
        @(posedge clk);
        #1;
        check("held_second_begins", busy, 1);
        start = 1'b0;
        wait_done(0, lat);
        check("held_second_latency", lat, 625);

        run_txn(7'h48, 8'h05, 8'hA7, 0, lat);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (194) @(posedge clk);
        #1;
        check("pre_reset_scl_low", scl_oe, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_lines", {scl_oe, sda_oe, busy}, 0);
        check("async_reset_data", data_out, 8'h00);
        nd = n_done;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        check("no_done_after_abort", n_done - nd, 0);

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_txn(7'h48, 8'h5C, 8'h81, 0, lat);
        check("first_edge_after_reset", lat, 625);

        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            d = 7'($urandom);
            if ($urandom_range(0, 3) != 0 || d == 7'h48) d = 7'h48;
            spur = $urandom_range(0, 1) == 1 ? $urandom_range(5, 150) : 0;
            run_txn(d, 8'($urandom), 8'($urandom), spur, lat);
            check("rand_latency", lat, d == 7'h48 ? 625 : 177);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
